nv_ram_rws_fifo_ctrl_32x272: RTL and testbench

//  Valid/ready FIFO controller that drives the write and read ports of an external 32x272
//  rws RAM macro and returns the read data as a stream.
//  The RAM registers its read address (ra_d) when re is high; dout = M[ra_d] is combinational,
//  so data is valid the cycle after re. A 2-entry registered output buffer absorbs that latency
//  and keeps full throughput.

---
 rtl/nv_ram_rws_fifo_pkg.sv | 14 +
 rtl/nv_ram_rws_fifo_obuf.sv | 59 +++++
 rtl/nv_ram_rws_fifo_ctrl_32x272.sv | 86 ++++++++
 tb/tb_nv_ram_rws_fifo_ctrl_32x272.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nv_ram_rws_fifo_pkg.sv
// Shared sizing and helpers for the 32x272 RAM-backed valid/ready FIFO controller.
package nv_ram_rws_fifo_pkg;
    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_AW    = 5;
    localparam int DEFAULT_WIDTH = 272;
    localparam int OBUF_DEPTH    = 2;

    typedef logic [1:0] ocnt_t;

    // Pointers are AW bits wide over a power-of-two depth, so wrap is free.
    function automatic logic [DEFAULT_AW-1:0] ptr_inc(input logic [DEFAULT_AW-1:0] ptr);
        return ptr + 1'b1;
    endfunction
endpackage

// File: rtl/nv_ram_rws_fifo_obuf.sv
// Two-entry in-order skid buffer that catches RAM read data and presents it to the consumer.
module nv_ram_rws_fifo_obuf
    import nv_ram_rws_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             land,
    input  logic [WIDTH-1:0] land_pd,
    input  logic             pop,
    output ocnt_t            out_cnt,
    output logic             rd_pvld,
    output logic [WIDTH-1:0] rd_pd
);
    logic [WIDTH-1:0] entry_reg  [OBUF_DEPTH];
    logic [WIDTH-1:0] entry_next [OBUF_DEPTH];
    ocnt_t            cnt_reg;
    ocnt_t            cnt_next;

    always_comb begin
        entry_next = entry_reg;
        cnt_next   = cnt_reg;
        unique case ({land, pop})
            2'b10: begin
                // Issue gating guarantees a free slot whenever data lands.
                entry_next[cnt_reg[0]] = land_pd;
                cnt_next               = cnt_reg + 2'd1;
            end
            2'b01: begin
                entry_next[0] = entry_reg[1];
                cnt_next      = cnt_reg - 2'd1;
            end
            2'b11: begin
                if (cnt_reg == 2'd2) begin
                    entry_next[0] = entry_reg[1];
                    entry_next[1] = land_pd;
                end else begin
                    entry_next[0] = land_pd;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) entry_reg[i] <= '0;
        end else begin
            cnt_reg <= cnt_next;
            for (int i = 0; i < OBUF_DEPTH; i++) entry_reg[i] <= entry_next[i];
        end
    end

    assign out_cnt = cnt_reg;
    assign rd_pvld = (cnt_reg != 2'd0);
    assign rd_pd   = entry_reg[0];
endmodule

// File: rtl/nv_ram_rws_fifo_ctrl_32x272.sv
// FIFO controller driving an external 32x272 RAM with a registered read address.
module nv_ram_rws_fifo_ctrl_32x272
    import nv_ram_rws_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [AW-1:0]    ram_ra,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [AW:0]      fifo_count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   ram_cnt_reg;
    logic [AW:0]   ram_cnt_next;
    logic          inflight_reg;
    ocnt_t         out_cnt;
    logic          push;
    logic          pop;
    logic          issue;
    logic [2:0]    occ_after;

    assign wr_prdy = (ram_cnt_reg != FULL_CNT);
    assign push    = wr_pvld & wr_prdy;
    assign pop     = rd_pvld & rd_prdy;

    // Output-side occupancy once this cycle's pop and any landing data settle;
    // a new read may only be launched if its data will have a slot to land in.
    assign occ_after = 3'(out_cnt) + 3'(inflight_reg) - 3'(pop);
    assign issue     = (ram_cnt_reg != '0) && (occ_after < 3'd2);

    always_comb begin
        ram_cnt_next = ram_cnt_reg;
        if (push && !issue)      ram_cnt_next = ram_cnt_reg + 1'b1;
        else if (!push && issue) ram_cnt_next = ram_cnt_reg - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ram_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
        end else begin
            if (push)  wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (issue) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            ram_cnt_reg  <= ram_cnt_next;
            inflight_reg <= issue;
        end
    end

    nv_ram_rws_fifo_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .land    (inflight_reg),
        .land_pd (ram_dout),
        .pop     (pop),
        .out_cnt (out_cnt),
        .rd_pvld (rd_pvld),
        .rd_pd   (rd_pd)
    );

    assign ram_we     = push;
    assign ram_wa     = wr_ptr_reg;
    assign ram_di     = wr_pd;
    assign ram_re     = issue;
    assign ram_ra     = rd_ptr_reg;
    assign fifo_count = ram_cnt_reg + (AW+1)'(inflight_reg) + (AW+1)'(out_cnt);
endmodule

// File: tb/tb_nv_ram_rws_fifo_ctrl_32x272.sv
// Randomized bench for the RAM-backed FIFO controller with a queue-based reference model.
module tb_nv_ram_rws_fifo_ctrl_32x272;
    import nv_ram_rws_fifo_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int WIDTH = 272;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_pvld = 1'b0;
    logic             wr_prdy;
    logic [WIDTH-1:0] wr_pd = '0;
    logic             rd_pvld;
    logic             rd_prdy = 1'b0;
    logic [WIDTH-1:0] rd_pd;
    logic             ram_we;
    logic [AW-1:0]    ram_wa;
    logic [WIDTH-1:0] ram_di;
    logic             ram_re;
    logic [AW-1:0]    ram_ra;
    logic [WIDTH-1:0] ram_dout;
    logic [AW:0]      fifo_count;

    always #5 clk = ~clk;

    nv_ram_rws_fifo_ctrl_32x272 dut (
        .clk        (clk),
        .rst        (rst),
        .wr_pvld    (wr_pvld),
        .wr_prdy    (wr_prdy),
        .wr_pd      (wr_pd),
        .rd_pvld    (rd_pvld),
        .rd_prdy    (rd_prdy),
        .rd_pd      (rd_pd),
        .ram_we     (ram_we),
        .ram_wa     (ram_wa),
        .ram_di     (ram_di),
        .ram_re     (ram_re),
        .ram_ra     (ram_ra),
        .ram_dout   (ram_dout),
        .fifo_count (fifo_count)
    );

    // RAM macro: write at the edge, read address registered, data combinational.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra_d = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
    end
    assign ram_dout = mem[ra_d];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: everything accepted and not yet delivered, oldest first.
    logic [WIDTH-1:0] q[$];
    int               n_acc;
    int               cyc;
    logic             stall_prev;
    logic [WIDTH-1:0] held_pd;
    logic             smp_re, smp_vld, smp_prdy, smp_push, smp_pop;
    logic [WIDTH-1:0] smp_pd;
    logic [AW:0]      smp_cnt;

    task automatic tick();
        @(negedge clk);
        smp_re   = ram_re;
        smp_vld  = rd_pvld;
        smp_pd   = rd_pd;
        smp_prdy = wr_prdy;
        smp_cnt  = fifo_count;
        smp_push = wr_pvld & wr_prdy;
        smp_pop  = rd_pvld & rd_prdy;
        chk("count", WIDTH'(fifo_count), WIDTH'(q.size()));
        chk("we", WIDTH'(ram_we), WIDTH'(smp_push));
        if (q.size() < DEPTH) chk("prdy_free", WIDTH'(wr_prdy), WIDTH'(1));
        if (q.size() == 0) chk("vld_empty", WIDTH'(rd_pvld), WIDTH'(0));
        if (stall_prev) begin
            chk("stall_vld", WIDTH'(rd_pvld), WIDTH'(1));
            chk("stall_pd", rd_pd, held_pd);
        end
        if (smp_pop) begin
            chk("pop_nonempty", WIDTH'(q.size() != 0), WIDTH'(1));
            if (q.size() != 0) chk("data", rd_pd, q.pop_front());
        end
        if (smp_push) begin
            q.push_back(wr_pd);
            n_acc++;
        end
        stall_prev = rd_pvld & ~rd_prdy;
        held_pd    = rd_pd;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        for (int i = 0; i < 200 && (q.size() != 0 || fifo_count != 0); i++) tick();
        chk("drain_done", WIDTH'(q.size()), WIDTH'(0));
    endtask

    function automatic logic [WIDTH-1:0] rand_pd();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < 9; i++) v[i*32 +: 32] = WIDTH'($urandom) ;
        return v;
    endfunction

    logic [WIDTH-1:0] pat_a5, pat_5a;
    int               next_data;
    int               first_pop, prdy_rise;
    logic             seen;

    initial begin
        n_acc = 0; cyc = 0; stall_prev = 1'b0; held_pd = '0;
        pat_a5 = {34{8'hA5}};
        pat_5a = {34{8'h5A}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", WIDTH'(rd_pvld), WIDTH'(0));
        chk("rst_prdy", WIDTH'(wr_prdy), WIDTH'(1));
        chk("rst_pd", rd_pd, WIDTH'(0));
        rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_re", WIDTH'(smp_re), WIDTH'(0));
            chk("idle_cnt", WIDTH'(smp_cnt), WIDTH'(0));
        end

        // Single beat latency
        rd_prdy = 1'b1;
        wr_pd   = pat_a5;
        for (int c = 0; c < 6; c++) begin
            wr_pvld = (c == 0);
            tick();
            chk("lat_re", WIDTH'(smp_re), WIDTH'(c == 1));
            chk("lat_vld", WIDTH'(smp_vld), WIDTH'(c == 3));
            if (c == 3) chk("lat_pd", smp_pd, pat_a5);
        end

        // Fill to capacity with the consumer stalled, then drain
        rd_prdy = 1'b0; wr_pvld = 1'b1; next_data = 0; n_acc = 0;
        for (int c = 0; c < 50; c++) begin
            wr_pd = WIDTH'(next_data);
            tick();
            if (smp_push) next_data++;
        end
        chk("fill_acc", WIDTH'(n_acc), WIDTH'(DEPTH + 2));
        chk("fill_prdy", WIDTH'(smp_prdy), WIDTH'(0));
        wr_pvld = 1'b0; rd_prdy = 1'b1; first_pop = -1; prdy_rise = -1;
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            tick();
            if (smp_pop && first_pop < 0) first_pop = cyc;
            if (smp_prdy && prdy_rise < 0) prdy_rise = cyc;
        end
        chk("prdy_rise", WIDTH'(prdy_rise - first_pop), WIDTH'(1));
        drain();

        // Streaming at full rate
        wr_pvld = 1'b1; rd_prdy = 1'b1; next_data = 1000;
        for (int c = 0; c < 100; c++) begin
            wr_pd = WIDTH'(next_data);
            tick();
            if (smp_push) next_data++;
            chk("stream_prdy", WIDTH'(smp_prdy), WIDTH'(1));
            if (c >= 3) begin
                chk("stream_vld", WIDTH'(smp_vld), WIDTH'(1));
                chk("stream_occ", WIDTH'(smp_cnt <= 3), WIDTH'(1));
            end
        end
        drain();

        // Random traffic with back-pressure, wrapping the pointers
        n_acc = 0;
        for (int c = 0; c < 3000 && n_acc < 200; c++) begin
            wr_pvld = ($urandom_range(3) != 0);
            rd_prdy = $urandom_range(1);
            wr_pd   = rand_pd();
            tick();
        end
        chk("rand_acc", WIDTH'(n_acc), WIDTH'(200));
        drain();

        // Asynchronous reset with data held
        rd_prdy = 1'b0; wr_pvld = 1'b1; n_acc = 0;
        for (int c = 0; c < 40 && n_acc < 20; c++) begin
            wr_pd = rand_pd();
            tick();
        end
        wr_pvld = 1'b0;
        tick();
        tick();
        rd_prdy = 1'b1;
        @(negedge clk);
        #1;
        chk("pre_rst_re", WIDTH'(ram_re), WIDTH'(1));
        chk("pre_rst_cnt", WIDTH'(fifo_count), WIDTH'(20));
        rst = 1'b1;
        #1;
        chk("arst_vld", WIDTH'(rd_pvld), WIDTH'(0));
        chk("arst_cnt", WIDTH'(fifo_count), WIDTH'(0));
        chk("arst_re", WIDTH'(ram_re), WIDTH'(0));
        chk("arst_prdy", WIDTH'(wr_prdy), WIDTH'(1));
        chk("arst_pd", rd_pd, WIDTH'(0));
        q.delete();
        stall_prev = 1'b0;
        rd_prdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_pvld = 1'b1; wr_pd = pat_5a;
        tick();
        wr_pvld = 1'b0; rd_prdy = 1'b1; seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (smp_vld) begin
                seen = 1'b1;
                chk("post_rst_pd", smp_pd, pat_5a);
            end
        end
        chk("post_rst_seen", WIDTH'(seen), WIDTH'(1));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
